spike_encoder: RTL and testbench

SPIKE_ENCODER -- requirements
Module: spike_encoder

---
 rtl/snn_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/spike_encoder.sv | 98 +++++++++
 tb/tb_spike_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and default widths for the spike address-event encoder.
package snn_pkg;

  localparam int NUM_NEURONS_D     = 16;
  localparam int ADDR_WIDTH_D      = $clog2(NUM_NEURONS_D);
  localparam int TIMESTAMP_WIDTH_D = 16;
  localparam int DROP_WIDTH_D      = 16;

  typedef struct packed {
    logic [ADDR_WIDTH_D-1:0]      addr;
    logic [TIMESTAMP_WIDTH_D-1:0] stamp;
  } spike_ev_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr,
// wrapping past the top index back to zero.
module rr_arbiter #(
  parameter int N  = 16,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [AW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any_grant && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = AW'(j);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// Spike-to-address-event encoder: pending latch per neuron,
// round-robin drain into a valid/ready output register.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS     = NUM_NEURONS_D,
  parameter int ADDR_WIDTH      = $clog2(NUM_NEURONS),
  parameter int TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_D,
  parameter int DROP_WIDTH      = DROP_WIDTH_D
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_NEURONS-1:0]     spike_in,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [ADDR_WIDTH-1:0]      ev_addr,
  output logic [TIMESTAMP_WIDTH-1:0] ev_time,
  input  logic                       clear_status,
  output logic                       overflow,
  output logic [DROP_WIDTH-1:0]      drop_count
);

  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int SUM_W = DROP_WIDTH + 1;

  logic [NUM_NEURONS-1:0]     pending;
  logic [NUM_NEURONS-1:0]     grant;
  logic [NUM_NEURONS-1:0]     kept;
  logic [NUM_NEURONS-1:0]     captured;
  logic [NUM_NEURONS-1:0]     dropped;
  logic [ADDR_WIDTH-1:0]      rr_ptr;
  logic [ADDR_WIDTH-1:0]      grant_idx;
  logic                       any_grant;
  logic                       loadable;
  logic [TIMESTAMP_WIDTH-1:0] ts;
  logic [CNT_W-1:0]           drop_n;
  logic [DROP_WIDTH-1:0]      drop_base;
  logic [SUM_W-1:0]           drop_sum;

  rr_arbiter #(
    .N  (NUM_NEURONS),
    .AW (ADDR_WIDTH)
  ) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // a granted bit is free again this cycle, so a new spike on it is no drop
  always_comb begin
    loadable  = !ev_valid || ev_ready;
    kept      = loadable ? (pending & ~grant) : pending;
    captured  = enable ? spike_in : '0;
    dropped   = captured & kept;
    drop_n    = '0;
    for (int i = 0; i < NUM_NEURONS; i++)
      drop_n = drop_n + CNT_W'(dropped[i]);
    drop_base = clear_status ? '0 : drop_count;
    drop_sum  = {1'b0, drop_base} + SUM_W'(drop_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid   <= 1'b0;
      ev_addr    <= '0;
      ev_time    <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
      ts         <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      ts      <= ts + 1'b1;
      pending <= kept | captured;
      if (loadable) begin
        ev_valid <= any_grant;
        if (any_grant) begin
          ev_addr <= grant_idx;
          ev_time <= ts;
          rr_ptr  <= (grant_idx == ADDR_WIDTH'(NUM_NEURONS - 1))
                     ? '0 : grant_idx + 1'b1;
        end
      end
      if (|dropped) begin
        overflow   <= 1'b1;
        drop_count <= drop_sum[DROP_WIDTH] ? '1
                      : drop_sum[DROP_WIDTH-1:0];
      end else if (clear_status) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: latency, burst drain, drops,
// hold under backpressure, reset mid-handshake, saturation, wrap.
module tb_spike_encoder;
  import snn_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] spike_in;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_addr;
  logic [15:0] ev_time;
  logic        clear_status;
  logic        overflow;
  logic [15:0] drop_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] model_ts;
  logic [15:0] cur;
  spike_ev_t   exp_list [4];

  spike_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .spike_in     (spike_in),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_addr      (ev_addr),
    .ev_time      (ev_time),
    .clear_status (clear_status),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    model_ts <= reset ? 16'h0 : model_ts + 16'h1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    spike_in     = '0;
    ev_ready     = 1'b1;
    clear_status = 1'b0;
    do_reset;

    chk("rst_valid", ev_valid, 0);
    chk("rst_addr", ev_addr, 0);
    chk("rst_time", ev_time, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);

    // single spike on neuron 5
    spike_in = 16'h0020;
    cur = model_ts;
    tick;
    spike_in = '0;
    chk("t1_early", ev_valid, 0);
    tick;
    chk("t1_valid", ev_valid, 1);
    chk("t1_addr", ev_addr, 5);
    chk("t1_time", ev_time, 16'(cur + 16'd1));
    tick;
    chk("t1_accepted", ev_valid, 0);

    // full burst drains in index order
    do_reset;
    spike_in = 16'hFFFF;
    cur = model_ts;
    tick;
    spike_in = '0;
    for (int k = 0; k < 16; k++) begin
      tick;
      chk("t2_valid", ev_valid, 1);
      chk("t2_addr", ev_addr, k);
      chk("t2_time", ev_time, 16'(cur + 16'd1 + 16'(k)));
    end
    tick;
    chk("t2_idle", ev_valid, 0);
    chk("t2_ovf", overflow, 0);

    // neuron 3 respikes while still pending behind held neuron 1
    ev_ready = 1'b0;
    spike_in = 16'h000A;
    cur = model_ts;
    tick;
    spike_in = '0;
    tick;
    tick;
    spike_in = 16'h0008;
    tick;
    spike_in = '0;
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_count, 1);
    chk("t3_valid", ev_valid, 1);
    chk("t3_addr", ev_addr, 1);
    clear_status = 1'b1;
    tick;
    clear_status = 1'b0;
    chk("t3_clr_ovf", overflow, 0);
    chk("t3_clr_drop", drop_count, 0);

    // held event stays stable under backpressure
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("t4_hold_addr", ev_addr, 1);
      chk("t4_hold_time", ev_time, 16'(cur + 16'd1));
    end

    // reset while holding an event with 4..7 pending
    do_reset;
    spike_in = 16'h00F8;
    tick;
    spike_in = '0;
    tick;
    chk("t5_valid", ev_valid, 1);
    chk("t5_addr", ev_addr, 3);
    reset = 1'b1;
    spike_in = 16'hFFFF;
    tick;
    chk("t5_rst_valid", ev_valid, 0);
    chk("t5_rst_addr", ev_addr, 0);
    chk("t5_rst_time", ev_time, 0);
    tick;
    reset = 1'b0;
    spike_in = '0;
    ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t5_no_event", ev_valid, 0);
    end

    // saturating drop counter
    ev_ready = 1'b0;
    spike_in = 16'hFFFF;
    tick;
    tick;
    tick;
    chk("t6_drop31", drop_count, 16'h001F);
    chk("t6_ovf", overflow, 1);
    for (int k = 0; k < 4200; k++)
      tick;
    chk("t6_sat", drop_count, 16'hFFFF);
    tick;
    chk("t6_sat_hold", drop_count, 16'hFFFF);
    clear_status = 1'b1;
    tick;
    clear_status = 1'b0;
    chk("t6_clr_drop", drop_count, 16);
    chk("t6_clr_ovf", overflow, 1);
    spike_in = '0;

    // timestamp wrap seen on consecutive events
    ev_ready = 1'b1;
    do_reset;
    for (int k = 0; k < 70000 && model_ts != 16'hFFFC; k++)
      tick;
    exp_list[0] = '{addr: 4'd2,  stamp: 16'hFFFD};
    exp_list[1] = '{addr: 4'd7,  stamp: 16'hFFFE};
    exp_list[2] = '{addr: 4'd9,  stamp: 16'hFFFF};
    exp_list[3] = '{addr: 4'd12, stamp: 16'h0000};
    spike_in = 16'h1284;
    tick;
    spike_in = '0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t7_valid", ev_valid, 1);
      chk("t7_addr", ev_addr, exp_list[k].addr);
      chk("t7_time", ev_time, exp_list[k].stamp);
    end
    tick;
    chk("t7_idle", ev_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
